// File: rtl/ifmap_row_packer_if.sv
// Pixel-stream and IFmap-buffer write bundle for ifmap_row_packer.
// master: the side that sources pixels and owns the buffer (drives s_valid,
//         s_data, buf_full). slave: the packer itself.
interface ifmap_row_packer_if #(
    parameter int DATA_WIDTH = 6,
    parameter int BUF_WIDTH  = 8
);
    logic                  s_valid;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  s_ready;
    logic                  buf_full;
    logic                  buf_wen;
    logic [BUF_WIDTH-1:0]  buf_din;

    modport master (
        output s_valid,
        output s_data,
        input  s_ready,
        output buf_full,
        input  buf_wen,
        input  buf_din
    );

    modport slave (
        input  s_valid,
        input  s_data,
        output s_ready,
        input  buf_full,
        output buf_wen,
        output buf_din
    );
endinterface

// File: rtl/ifmap_row_packer.sv
// ifmap_row_packer: tags each incoming IFmap pixel with row-start (MSB) and
// row-end (MSB-1) flags and writes it into the IFmap buffer through a
// one-entry output register. Row length and row count are latched on start.
// Optional: define IFMAP_PACKER_STALL_CNT_EN to add a saturating 16-bit
// stall_cycles output counting cycles the output word waits on buf_full.
module ifmap_row_packer #(
    parameter int DATA_WIDTH = 6,
    parameter int BUF_WIDTH  = 8,
    parameter int LEN_WIDTH  = 5
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [LEN_WIDTH-1:0] row_len,
    input  logic [LEN_WIDTH-1:0] num_rows,
    ifmap_row_packer_if.slave    bus,
    output logic                 busy,
    output logic                 frame_done,
`ifdef IFMAP_PACKER_STALL_CNT_EN
    output logic [15:0]          stall_cycles,
`endif
    output logic                 cfg_error
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN
    } state_t;

    state_t state, state_nxt;

    logic [LEN_WIDTH-1:0] row_len_q;
    logic [LEN_WIDTH-1:0] num_rows_q;
    logic [LEN_WIDTH-1:0] pix_cnt;
    logic [LEN_WIDTH-1:0] row_cnt;
    logic                 out_valid;
    logic [BUF_WIDTH-1:0] out_word;

    logic start_ok;
    logic start_bad;
    logic row_last;
    logic frame_last;
    logic accept;
    logic wen;
    logic ready;
    logic busy_c;
    logic done_nxt;

    assign start_ok   = start && (row_len != '0) && (num_rows != '0);
    assign start_bad  = start && !start_ok;
    assign row_last   = (pix_cnt == row_len_q - LEN_WIDTH'(1));
    assign frame_last = row_last && (row_cnt == num_rows_q - LEN_WIDTH'(1));

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // FSM next-state and handshake decode
    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        busy_c    = 1'b0;
        accept    = 1'b0;
        done_nxt  = 1'b0;
        wen       = out_valid && !bus.buf_full;
        case (state)
            IDLE: begin
                if (start_ok) state_nxt = RUN;
            end
            RUN: begin
                busy_c = 1'b1;
                ready  = !out_valid || !bus.buf_full;
                accept = bus.s_valid && ready;
                if (accept && frame_last) state_nxt = DRAIN;
            end
            DRAIN: begin
                busy_c = 1'b1;
                if (wen) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Config latch, row/pixel counters, output register and status flags
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_len_q  <= '0;
            num_rows_q <= '0;
            pix_cnt    <= '0;
            row_cnt    <= '0;
            out_valid  <= 1'b0;
            out_word   <= '0;
            frame_done <= 1'b0;
            cfg_error  <= 1'b0;
        end else begin
            frame_done <= done_nxt;
            if (state == IDLE) begin
                if (start_ok) begin
                    row_len_q  <= row_len;
                    num_rows_q <= num_rows;
                    pix_cnt    <= '0;
                    row_cnt    <= '0;
                    cfg_error  <= 1'b0;
                end else if (start_bad) begin
                    cfg_error  <= 1'b1;
                end
            end
            // A write and an accept in the same cycle simply reload the
            // register, so out_valid stays set.
            if (accept) begin
                out_word  <= {(pix_cnt == '0), row_last, bus.s_data};
                out_valid <= 1'b1;
                if (row_last) begin
                    pix_cnt <= '0;
                    row_cnt <= row_cnt + LEN_WIDTH'(1);
                end else begin
                    pix_cnt <= pix_cnt + LEN_WIDTH'(1);
                end
            end else if (wen) begin
                out_valid <= 1'b0;
            end
        end
    end

`ifdef IFMAP_PACKER_STALL_CNT_EN
    // Saturating count of cycles the pending word is blocked by buf_full
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cycles <= '0;
        end else if (state == IDLE) begin
            if (start_ok) stall_cycles <= '0;
        end else if (out_valid && bus.buf_full && (stall_cycles != '1)) begin
            stall_cycles <= stall_cycles + 16'd1;
        end
    end
`endif

    assign bus.s_ready = ready;
    assign bus.buf_wen = wen;
    assign bus.buf_din = out_word;
    assign busy        = busy_c;

endmodule

// File: tb/tb_ifmap_row_packer.sv
// Self-checking bench for ifmap_row_packer: a per-cycle vector table for the
// plain frame, single-pixel rows, illegal config and start-during-run cases,
// plus hand-written backpressure and mid-frame reset sequences.
module tb_ifmap_row_packer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       start = 1'b0;
    logic [4:0] row_len = '0;
    logic [4:0] num_rows = '0;
    logic       busy;
    logic       frame_done;
    logic       cfg_error;
`ifdef IFMAP_PACKER_STALL_CNT_EN
    logic [15:0] stall_cycles;
`endif

    int unsigned tests  = 0;
    int unsigned failed = 0;

    ifmap_row_packer_if #(.DATA_WIDTH(6), .BUF_WIDTH(8)) bus ();

    ifmap_row_packer #(
        .DATA_WIDTH(6),
        .BUF_WIDTH (8),
        .LEN_WIDTH (5)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .row_len   (row_len),
        .num_rows  (num_rows),
        .bus       (bus),
        .busy      (busy),
        .frame_done(frame_done),
`ifdef IFMAP_PACKER_STALL_CNT_EN
        .stall_cycles(stall_cycles),
`endif
        .cfg_error (cfg_error)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic [4:0] rl;
        logic [4:0] nr;
        logic       sv;
        logic [5:0] sd;
        logic       bf;
        logic       e_rdy;
        logic       e_wen;
        logic [7:0] e_din;
        logic       e_busy;
        logic       e_done;
        logic       e_err;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic st, input logic [4:0] rl, input logic [4:0] nr,
                                input logic sv, input logic [5:0] sd, input logic bf,
                                input logic e_rdy, input logic e_wen, input logic [7:0] e_din,
                                input logic e_busy, input logic e_done, input logic e_err);
        vec_t v;
        v.st = st; v.rl = rl; v.nr = nr; v.sv = sv; v.sd = sd; v.bf = bf;
        v.e_rdy = e_rdy; v.e_wen = e_wen; v.e_din = e_din;
        v.e_busy = e_busy; v.e_done = e_done; v.e_err = e_err;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic st, input logic [4:0] rl, input logic [4:0] nr,
                         input logic sv, input logic [5:0] sd, input logic bf);
        start = st; row_len = rl; num_rows = nr;
        bus.s_valid = sv; bus.s_data = sd; bus.buf_full = bf;
    endtask

    initial begin
        logic [7:0] bp_exp [4];
        logic [5:0] bp_pix [4];
        int unsigned writes;
        int unsigned full_left;
        int unsigned idx;
        bit          done_seen;

        drive(0, 0, 0, 0, 0, 0);

        // ---- reset state ----
        #2 rst = 1'b1;
        #1;
        chk("reset s_ready",    16'(bus.s_ready),  16'h0);
        chk("reset buf_wen",    16'(bus.buf_wen),  16'h0);
        chk("reset buf_din",    16'(bus.buf_din),  16'h0);
        chk("reset busy",       16'(busy),         16'h0);
        chk("reset frame_done", 16'(frame_done),   16'h0);
        chk("reset cfg_error",  16'(cfg_error),    16'h0);
        @(negedge clk);
        rst = 1'b0;

        // ---- basic frame: row_len=3, num_rows=2, pixels 1..6 ----
        //                st rl nr sv sd bf   rdy wen din    busy done err
        tbl.push_back(mk(1, 3, 2, 0, 0, 0,   0,  0,  8'h00, 0,   0,   0));
        tbl.push_back(mk(0, 0, 0, 1, 1, 0,   1,  0,  8'h00, 1,   0,   0));
        tbl.push_back(mk(0, 0, 0, 1, 2, 0,   1,  1,  8'h81, 1,   0,   0));
        tbl.push_back(mk(0, 0, 0, 1, 3, 0,   1,  1,  8'h02, 1,   0,   0));
        tbl.push_back(mk(0, 0, 0, 1, 4, 0,   1,  1,  8'h43, 1,   0,   0));
        tbl.push_back(mk(0, 0, 0, 1, 5, 0,   1,  1,  8'h84, 1,   0,   0));
        tbl.push_back(mk(0, 0, 0, 1, 6, 0,   1,  1,  8'h05, 1,   0,   0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0,  1,  8'h46, 1,   0,   0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0,  0,  8'h46, 0,   1,   0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0,  0,  8'h46, 0,   0,   0));
        // ---- single-pixel rows: row_len=1, num_rows=3, pixels 5,6,7 ----
        tbl.push_back(mk(1, 1, 3, 0, 0, 0,   0,  0,  8'h46, 0,   0,   0));
        tbl.push_back(mk(0, 0, 0, 1, 5, 0,   1,  0,  8'h46, 1,   0,   0));
        tbl.push_back(mk(0, 0, 0, 1, 6, 0,   1,  1,  8'hC5, 1,   0,   0));
        tbl.push_back(mk(0, 0, 0, 1, 7, 0,   1,  1,  8'hC6, 1,   0,   0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0,  1,  8'hC7, 1,   0,   0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0,  0,  8'hC7, 0,   1,   0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0,  0,  8'hC7, 0,   0,   0));
        // ---- illegal config, then legal start clears cfg_error ----
        tbl.push_back(mk(1, 0, 4, 1, 9, 0,   0,  0,  8'hC7, 0,   0,   0));
        tbl.push_back(mk(0, 0, 0, 1, 9, 0,   0,  0,  8'hC7, 0,   0,   1));
        tbl.push_back(mk(1, 5, 0, 0, 0, 0,   0,  0,  8'hC7, 0,   0,   1));
        tbl.push_back(mk(1, 3, 2, 0, 0, 0,   0,  0,  8'hC7, 0,   0,   1));
        // ---- start with row_len=7 mid-frame is ignored ----
        tbl.push_back(mk(0, 0, 0, 1, 1, 0,   1,  0,  8'hC7, 1,   0,   0));
        tbl.push_back(mk(1, 7, 1, 1, 2, 0,   1,  1,  8'h81, 1,   0,   0));
        tbl.push_back(mk(0, 0, 0, 1, 3, 0,   1,  1,  8'h02, 1,   0,   0));
        tbl.push_back(mk(0, 0, 0, 1, 4, 0,   1,  1,  8'h43, 1,   0,   0));
        tbl.push_back(mk(0, 0, 0, 1, 5, 0,   1,  1,  8'h84, 1,   0,   0));
        tbl.push_back(mk(0, 0, 0, 1, 6, 0,   1,  1,  8'h05, 1,   0,   0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0,  1,  8'h46, 1,   0,   0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 0,   0,  0,  8'h46, 0,   1,   0));

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            drive(tbl[i].st, tbl[i].rl, tbl[i].nr, tbl[i].sv, tbl[i].sd, tbl[i].bf);
            #1;
            chk($sformatf("vec%0d s_ready", i),    16'(bus.s_ready), 16'(tbl[i].e_rdy));
            chk($sformatf("vec%0d buf_wen", i),    16'(bus.buf_wen), 16'(tbl[i].e_wen));
            chk($sformatf("vec%0d buf_din", i),    16'(bus.buf_din), 16'(tbl[i].e_din));
            chk($sformatf("vec%0d busy", i),       16'(busy),        16'(tbl[i].e_busy));
            chk($sformatf("vec%0d frame_done", i), 16'(frame_done),  16'(tbl[i].e_done));
            chk($sformatf("vec%0d cfg_error", i),  16'(cfg_error),   16'(tbl[i].e_err));
        end

        // ---- backpressure: row_len=4, buf_full for 5 cycles after 2nd write ----
        bp_pix[0] = 6'h0A; bp_pix[1] = 6'h0B; bp_pix[2] = 6'h0C; bp_pix[3] = 6'h0D;
        bp_exp[0] = 8'h8A; bp_exp[1] = 8'h0B; bp_exp[2] = 8'h0C; bp_exp[3] = 8'h4D;
        @(negedge clk);
        drive(1, 4, 1, 0, 0, 0);
        writes = 0; full_left = 0; idx = 0; done_seen = 0;
        for (int cyc = 0; cyc < 40 && !done_seen; cyc++) begin
            @(negedge clk);
            drive(0, 0, 0, idx < 4, (idx < 4) ? bp_pix[idx] : 6'h0, full_left > 0);
            #1;
            if (bus.buf_full) begin
                chk("bp stall buf_wen", 16'(bus.buf_wen), 16'h0);
                chk("bp stall s_ready", 16'(bus.s_ready), 16'h0);
                chk("bp stall buf_din", 16'(bus.buf_din), 16'(bp_exp[2]));
                full_left--;
            end
            if (bus.buf_wen) begin
                if (writes < 4) begin
                    chk($sformatf("bp word%0d", writes), 16'(bus.buf_din), 16'(bp_exp[writes]));
                end else begin
                    chk("bp extra write", 16'(writes), 16'd3);
                end
                writes++;
                if (writes == 2) full_left = 5;
            end
            if (bus.s_valid && bus.s_ready) idx++;
            if (frame_done) done_seen = 1;
        end
        chk("bp total writes",   16'(writes),    16'd4);
        chk("bp pixels taken",   16'(idx),       16'd4);
        chk("bp frame_done seen", 16'(done_seen), 16'd1);
`ifdef IFMAP_PACKER_STALL_CNT_EN
        chk("bp stall_cycles", stall_cycles, 16'd5);
`endif

        // ---- reset mid-frame after 2 of 6 pixels ----
        @(negedge clk);
        drive(1, 3, 2, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 1, 6'h01, 0);
        @(negedge clk);
        drive(0, 0, 0, 1, 6'h02, 0);
        @(negedge clk);
        drive(0, 0, 0, 1, 6'h03, 0);
        #1;
        chk("pre-reset buf_wen", 16'(bus.buf_wen), 16'h1);
        chk("pre-reset buf_din", 16'(bus.buf_din), 16'h02);
        #1 rst = 1'b1;
        #1;
        chk("mid rst s_ready",    16'(bus.s_ready), 16'h0);
        chk("mid rst buf_wen",    16'(bus.buf_wen), 16'h0);
        chk("mid rst buf_din",    16'(bus.buf_din), 16'h0);
        chk("mid rst busy",       16'(busy),        16'h0);
        chk("mid rst frame_done", 16'(frame_done),  16'h0);
        chk("mid rst cfg_error",  16'(cfg_error),   16'h0);
        @(negedge clk);
        rst = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        drive(1, 2, 1, 0, 0, 0);
        @(negedge clk);
        drive(0, 0, 0, 1, 6'h09, 0);
        #1;
        chk("post rst s_ready", 16'(bus.s_ready), 16'h1);
        @(negedge clk);
        drive(0, 0, 0, 1, 6'h0A, 0);
        #1;
        chk("post rst word0 wen", 16'(bus.buf_wen), 16'h1);
        chk("post rst word0 din", 16'(bus.buf_din), 16'h89);
        @(negedge clk);
        drive(0, 0, 0, 0, 0, 0);
        #1;
        chk("post rst word1 wen", 16'(bus.buf_wen), 16'h1);
        chk("post rst word1 din", 16'(bus.buf_din), 16'h4A);
        @(negedge clk);
        #1;
        chk("post rst frame_done", 16'(frame_done), 16'h1);
        chk("post rst busy",       16'(busy),       16'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule

// File: doc/ifmap_row_packer.md
Name: ifmap_row_packer

Overview:
- Upstream feeder for the IFmap circular buffer.
- Accepts a raw IFmap pixel stream over a valid/ready handshake and tags each word with row-start (MSB) and row-end (MSB-1) flags.
- Writes tagged words into the IFmap buffer through its write_enable/full interface.
- Row length and row count are latched per frame, so the downstream status decoder sees correct start/end status for every filter row.

Parameters:
- DATA_WIDTH, 6, raw pixel width (matches IFmap scratch-pad width).
- BUF_WIDTH, 8, buffer word width; must equal DATA_WIDTH+2.
- LEN_WIDTH, 5, width of the row-length and row-count fields.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle pulse; latches config and begins a frame.
- row_len  in  LEN_WIDTH  pixels per row; latched on start.
- num_rows  in  LEN_WIDTH  rows per frame; latched on start.
- s_valid  in  1  input pixel valid.
- s_data  in  DATA_WIDTH  input pixel.
- s_ready  out  1  packer can accept a pixel this cycle.
- buf_full  in  1  IFmap buffer full.
- buf_wen  out  1  write strobe to the IFmap buffer.
- buf_din  out  BUF_WIDTH  {start_bit, end_bit, pixel}.
- busy  out  1  frame in progress.
- frame_done  out  1  one-cycle pulse after the last word is written.
- cfg_error  out  1  sticky; set on illegal config.

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE; all counters and latched config clear to 0.
  - Output register is empty.
  - s_ready, buf_wen, busy, frame_done, cfg_error = 0; buf_din = 0.
- FSM states: IDLE, RUN, DRAIN.
- IDLE:
  - s_ready=0.
  - start with row_len!=0 and num_rows!=0: latch both values, clear pix_cnt and row_cnt, go to RUN.
  - start with either value 0: set cfg_error, stay in IDLE.
  - cfg_error clears only on rst or on the next legal start.
- RUN:
  - busy=1.
  - A pixel is accepted when s_valid && s_ready.
  - Each accepted pixel loads the 1-entry output register:
    - pixel bits from s_data;
    - start_bit=(pix_cnt==0);
    - end_bit=(pix_cnt==row_len-1).
  - pix_cnt increments per accepted pixel and wraps to 0 after row_len-1; row_cnt increments on that wrap.
  - When the last pixel of row num_rows-1 is accepted, go to DRAIN.
- Single-pixel rows (row_len=1): every word carries start=1 and end=1 (status 11).
- Output register handshake:
  - buf_wen = out_valid && !buf_full.
  - buf_din is held stable while out_valid && buf_full.
  - s_ready = (state==RUN) && (!out_valid || !buf_full). This gives full throughput with one word per cycle.
  - Latency: a pixel accepted in cycle N is written at cycle N+1 at the earliest.
- Simultaneous write and accept in the same cycle: the register is overwritten with the new pixel and out_valid stays 1.
- DRAIN:
  - s_ready=0.
  - When the final word is written (buf_wen=1), pulse frame_done for one cycle and go to IDLE.
  - busy drops in the cycle frame_done is high.
- start during RUN or DRAIN is ignored; latched config does not change mid-frame.
- buf_full held high indefinitely: the word is held, no data is lost, and s_ready stays 0.
- Reset mid-frame: the pending output word is discarded, buf_wen drops immediately, and the FSM returns to IDLE.
- Counter widths: pix_cnt and row_cnt are LEN_WIDTH bits; compare against row_len-1 and num_rows-1 computed in LEN_WIDTH arithmetic.

Optional Feature:
- Macro: IFMAP_PACKER_STALL_CNT_EN.
- When defined:
  - Adds output stall_cycles, 16 bits.
  - It counts cycles in RUN/DRAIN with out_valid && buf_full.
  - It saturates at 16'hFFFF and clears on rst or on a legal start.
- When not defined: the port and the counter are absent, and all other behaviour is identical.

Test Plan:
- Basic frame: start, row_len=3, num_rows=2; pixels 1..6 with buf_full=0 → six back-to-back writes of buf_din = 8'h81, 8'h02, 8'h43, 8'h84, 8'h05, 8'h46; frame_done pulses 1 cycle after the 6th write.
- Single-pixel rows: row_len=1, num_rows=3, pixels 5,6,7 → buf_din = 8'hC5, 8'hC6, 8'hC7; busy=0 after frame_done.
- Backpressure: row_len=4; hold buf_full=1 for 5 cycles after the 2nd word → buf_wen=0, buf_din stable, s_ready=0 throughout; resumes with no loss or duplication (4 writes total).
- Illegal config: start with row_len=0 → cfg_error=1, stays IDLE, s_ready=0; a following legal start clears cfg_error.
- Reset mid-frame: assert rst after 2 of 6 pixels → all outputs 0 in the same cycle; a new start with row_len=2 gives a fresh start_bit=1 on the first word.
- start during RUN: pulse start with row_len=7 mid-frame → ignored; row boundaries follow the original row_len=3.
